// File: rtl/alu_div6_if.sv
// Operand/result handshake bundle for the alu_div6 restoring divider.
// The master supplies operands and accepts results; the slave is the divider.
interface alu_div6_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] quotient;
    logic [5:0]  remainder;
    logic        div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/alu_div6.sv
// 12/6-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Define ALU_DIV_ZERO_DETECT_EN to short-circuit a zero divisor straight to DONE with div_zero=1.
module alu_div6 (
    input  logic       clk,
    input  logic       rst,
    alu_div6_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [11:0] dvd_reg;   // dividend shifts out the top, quotient bits shift in the bottom
    logic [5:0]  pr_reg;
    logic [5:0]  dvs_reg;
    logic [3:0]  cnt_reg;
    logic        dz_reg;

    logic [6:0]  pr_shift;
    logic [5:0]  pr_diff;
    logic        q_bit;
    logic        zero_skip;

`ifdef ALU_DIV_ZERO_DETECT_EN
    assign zero_skip = (bus.divisor == 6'd0);
`else
    assign zero_skip = 1'b0;
`endif

    // The 7-bit partial remainder; after a subtract it always fits back in 6 bits.
    always_comb begin
        pr_shift = {pr_reg, dvd_reg[11]};
        q_bit    = (pr_shift >= {1'b0, dvs_reg});
        pr_diff  = pr_shift[5:0];
        if (q_bit) begin
            pr_diff = 6'(pr_shift - {1'b0, dvs_reg});
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.in_valid) state_next = zero_skip ? DONE : RUN;
            RUN:  if (cnt_reg == 4'd11) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_reg <= 12'd0;
            pr_reg  <= 6'd0;
            dvs_reg <= 6'd0;
            cnt_reg <= 4'd0;
            dz_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvs_reg <= bus.divisor;
                        cnt_reg <= 4'd0;
                        if (zero_skip) begin
                            dvd_reg <= 12'hFFF;
                            pr_reg  <= bus.dividend[5:0];
                            dz_reg  <= 1'b1;
                        end else begin
                            dvd_reg <= bus.dividend;
                            pr_reg  <= 6'd0;
                            dz_reg  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    pr_reg  <= pr_diff;
                    dvd_reg <= {dvd_reg[10:0], q_bit};
                    cnt_reg <= cnt_reg + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.quotient  = dvd_reg;
    assign bus.remainder = pr_reg;
    assign bus.div_zero  = dz_reg;
endmodule

// File: tb/tb_alu_div6.sv
// Directed and randomised checks of alu_div6: latency, results, backpressure, zero divisor, reset abort.
// Expectations follow ALU_DIV_ZERO_DETECT_EN when it is defined for the build.
module tb_alu_div6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_div6_if bus();

    alu_div6 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation, check latency and result, optionally stall the consumer.
    task automatic run_div(input logic [11:0] a, input logic [5:0] b,
                           input logic [11:0] exp_q, input logic [5:0] exp_r,
                           input logic exp_dz, input int exp_lat, input int stall,
                           input bit verbose);
        int cyc;
        logic [11:0] q_seen;
        logic [5:0]  r_seen;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        if (verbose) check_eq("in_ready_before", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = 12'(~a);
        bus.divisor  = 6'(b + 6'd13);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (verbose || cyc != exp_lat) check_eq("latency", 32'(cyc), 32'(exp_lat));
        q_seen = bus.quotient;
        r_seen = bus.remainder;
        check_eq("quotient", 32'(q_seen), 32'(exp_q));
        check_eq("remainder", 32'(r_seen), 32'(exp_r));
        if (verbose) check_eq("div_zero", 32'(bus.div_zero), 32'(exp_dz));
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("hold_quotient", 32'(bus.quotient), 32'(exp_q));
            check_eq("hold_remainder", 32'(bus.remainder), 32'(exp_r));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (verbose) begin
            check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
            check_eq("release_out_valid", 32'(bus.out_valid), 32'd0);
            $display("div %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, q_seen, r_seen, exp_dz, cyc);
        end
    endtask

    initial begin
        logic [11:0] ra;
        logic [5:0]  rb;
        int          gap;
        int          zlat;
        logic        zdz;
        bit          saw_valid;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = 12'd0;
        bus.divisor   = 6'd0;
`ifdef ALU_DIV_ZERO_DETECT_EN
        zlat = 1;  zdz = 1'b1;
`else
        zlat = 12; zdz = 1'b0;
`endif

        #12;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_quotient", 32'(bus.quotient), 32'd0);
        check_eq("rst_remainder", 32'(bus.remainder), 32'd0);
        check_eq("rst_div_zero", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(12'd100,  6'd7,  12'd14,   6'd2,  1'b0, 12, 0, 1);
        run_div(12'd3969, 6'd63, 12'd63,   6'd0,  1'b0, 12, 0, 1);
        run_div(12'd4095, 6'd1,  12'd4095, 6'd0,  1'b0, 12, 0, 1);
        run_div(12'd4095, 6'd63, 12'd65,   6'd0,  1'b0, 12, 0, 1);
        run_div(12'd62,   6'd63, 12'd0,    6'd62, 1'b0, 12, 0, 1);
        run_div(12'd0,    6'd5,  12'd0,    6'd0,  1'b0, 12, 0, 1);
        run_div(12'd50,   6'd6,  12'd8,    6'd2,  1'b0, 12, 5, 1);
        run_div(12'd1234, 6'd0,  12'hFFF,  6'd18, zdz,  zlat, 0, 1);
        run_div(12'd77,   6'd10, 12'd7,    6'd7,  1'b0, 12, 0, 1);

        // Abort 200/9 five steps into RUN; no result may follow.
        bus.dividend = 12'd200;
        bus.divisor  = 6'd9;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_quotient", 32'(bus.quotient), 32'd0);
        check_eq("abort_remainder", 32'(bus.remainder), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check_eq("abort_no_valid", 32'(saw_valid), 32'd0);
        $display("abort 200 / 9 at step 5 -> outputs cleared");
        run_div(12'd200, 6'd9, 12'd22, 6'd2, 1'b0, 12, 0, 1);

        for (int t = 0; t < 300; t++) begin
            ra  = 12'($urandom);
            rb  = 6'($urandom_range(1, 63));
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            #1;
            run_div(ra, rb, ra / 12'(rb), 6'(ra % 12'(rb)), 1'b0, 12,
                    $urandom_range(0, 2), 0);
        end
        $display("random: 300 operand pairs issued");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
